// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one uart_tx among NUM_REQ clients.
// Optional grant-revocation timeout in FETCH enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         active,
  output logic                         tx_send,
  output logic [DATA_BITS-1:0]         tx_data,
  input  logic                         tx_busy,
  output logic                         err_timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    WAIT_BUSY,
    DRAIN
  } state_t;

  state_t               state;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        win;
  logic [IW-1:0]        arb_idx;
  logic [IW-1:0]        cand;
  logic                 arb_hit;
  logic                 last_q;
  logic                 win_valid;
  logic                 win_last;
  logic [DATA_BITS-1:0] win_data;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic          err_q;
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  // Search starts one past the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(ptr) + k) % NUM_REQ);
      if (!arb_hit && req_valid[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  assign win_valid = req_valid[win];
  assign win_last  = req_last[win];
  assign win_data  = req_data[int'(win)*DATA_BITS +: DATA_BITS];

  assign req_ready = (state == FETCH) ? grant : '0;
  assign active    = |grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      ptr     <= IW'(NUM_REQ - 1);
      win     <= '0;
      tx_send <= 1'b0;
      tx_data <= '0;
      last_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      tcnt    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
`ifdef UART_ARB_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (arb_hit) begin
            grant <= NUM_REQ'(1) << arb_idx;
            ptr   <= arb_idx;
            win   <= arb_idx;
            state <= FETCH;
`ifdef UART_ARB_TIMEOUT_EN
            tcnt  <= '0;
`endif
          end
        end
        FETCH: begin
          if (win_valid) begin
            tx_data <= win_data;
            last_q  <= win_last;
            tx_send <= 1'b1;
            state   <= SEND;
`ifdef UART_ARB_TIMEOUT_EN
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            // Revoke; ptr already points at this winner, so it drops to lowest priority.
            grant <= '0;
            err_q <= 1'b1;
            state <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
`endif
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_send <= 1'b0;
            state   <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!tx_busy) begin
            if (last_q) begin
              grant <= '0;
              state <= IDLE;
            end else begin
              state <= FETCH;
`ifdef UART_ARB_TIMEOUT_EN
              tcnt  <= '0;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
